pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the Fyre RV32I fetch stage, replacing the fixed-width counter that only supports increment and write. Holds the fetch PC and advances it by a configurable step. Accepts prioritised redirects (trap, trap-return, branch/jump) and stalls. Inserts a configurable flush bubble after every redirect and keeps an exception PC register for trap return.

---
 rtl/pc_sequencer.sv | 119 +++++++++++
 tb/tb_pc_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: step/stall, prioritised trap/mret/write redirects, post-redirect flush bubble, EPC.
// Optional `PC_MISALIGN_CHECK_EN turns misaligned write targets into traps and pulses misalign.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VEC    = '0,
  parameter logic [XLEN-1:0] TRAP_VEC     = XLEN'('h100),
  parameter int              INC          = 4,
  parameter int              FLUSH_CYCLES = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            stall,
  input  logic            write,
  input  logic [XLEN-1:0] addr,
  input  logic            trap,
  input  logic            mret,
  output logic [XLEN-1:0] curr,
  output logic [XLEN-1:0] next,
  output logic [XLEN-1:0] epc,
  output logic            valid,
  output logic            misalign
);

  typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_BUBBLE} state_t;

  localparam logic [2:0] BCNT_LOAD = (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;
  localparam logic       NO_FLUSH  = (FLUSH_CYCLES == 0);

  state_t          state, state_nxt;
  logic [XLEN-1:0] curr_q, curr_d, epc_q, epc_d, write_tgt;
  logic            valid_q, valid_d, mis_q, mis_d;
  logic [2:0]      bcnt_q, bcnt_d;
  logic            active, bad_write, take_trap, take_mret, take_write, redirect;

`ifdef PC_MISALIGN_CHECK_EN
  assign bad_write = (addr[1:0] != 2'b00);
  assign write_tgt = addr;
`else
  assign bad_write = 1'b0;
  assign write_tgt = addr & ~XLEN'(3);
`endif

  // Redirects are ignored until the FSM has left RESET.
  assign active     = (state != ST_RESET);
  assign take_trap  = active & (trap | (~mret & write & bad_write));
  assign take_mret  = active & ~trap & mret;
  assign take_write = active & ~trap & ~mret & write & ~bad_write;
  assign redirect   = take_trap | take_mret | take_write;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_RESET;
      curr_q  <= RESET_VEC;
      epc_q   <= '0;
      valid_q <= 1'b0;
      bcnt_q  <= 3'd0;
      mis_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      curr_q  <= curr_d;
      epc_q   <= epc_d;
      valid_q <= valid_d;
      bcnt_q  <= bcnt_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET:  state_nxt = ST_RUN;
      ST_RUN:    if (redirect && !NO_FLUSH) state_nxt = ST_BUBBLE;
      ST_BUBBLE: begin
        if (redirect) state_nxt = NO_FLUSH ? ST_RUN : ST_BUBBLE;
        else if (bcnt_q == 3'd0) state_nxt = ST_RUN;
      end
      default:   state_nxt = ST_RESET;
    endcase
  end

  always_comb begin
    curr_d  = curr_q;
    epc_d   = epc_q;
    valid_d = valid_q;
    bcnt_d  = bcnt_q;
    mis_d   = active & ~trap & ~mret & write & bad_write;
    if (state == ST_RESET) begin
      valid_d = 1'b1;
    end else begin
      if (take_trap) begin
        epc_d  = curr_q;
        curr_d = TRAP_VEC;
      end else if (take_mret) begin
        curr_d = epc_q;
      end else if (take_write) begin
        curr_d = write_tgt;
      end

      if (redirect) begin
        valid_d = NO_FLUSH;
        bcnt_d  = BCNT_LOAD;
      end else if (state == ST_RUN) begin
        valid_d = 1'b1;
        if (!stall) curr_d = next;
      end else if (bcnt_q == 3'd0) begin
        valid_d = 1'b1;
      end else begin
        bcnt_d = bcnt_q - 3'd1;
      end
    end
  end

  assign curr     = curr_q;
  assign next     = curr_q + XLEN'(INC);
  assign epc      = epc_q;
  assign valid    = valid_q;
  assign misalign = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default, FLUSH_CYCLES=3 and wrapping RESET_VEC instances share stimulus.
module tb_pc_sequencer;
  logic        CLK = 1'b0;
  logic        RST, stall, write, trap, mret;
  logic [31:0] addr;

  logic [31:0] a_curr, a_next, a_epc, b_curr, b_next, b_epc, c_curr, c_next, c_epc;
  logic        a_valid, a_mis, b_valid, b_mis, c_valid, c_mis;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  pc_sequencer u_a (
    .CLK(CLK), .RST(RST), .stall(stall), .write(write), .addr(addr), .trap(trap), .mret(mret),
    .curr(a_curr), .next(a_next), .epc(a_epc), .valid(a_valid), .misalign(a_mis));

  pc_sequencer #(.FLUSH_CYCLES(3)) u_b (
    .CLK(CLK), .RST(RST), .stall(stall), .write(write), .addr(addr), .trap(trap), .mret(mret),
    .curr(b_curr), .next(b_next), .epc(b_epc), .valid(b_valid), .misalign(b_mis));

  pc_sequencer #(.RESET_VEC(32'hFFFF_FFF8)) u_c (
    .CLK(CLK), .RST(RST), .stall(stall), .write(write), .addr(addr), .trap(trap), .mret(mret),
    .curr(c_curr), .next(c_next), .epc(c_epc), .valid(c_valid), .misalign(c_mis));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; stall = 1'b0; write = 1'b0; trap = 1'b0; mret = 1'b0; addr = '0;

    // Reset and run
    step(); step();
    chk("rst_curr", a_curr, 32'h0);
    chk("rst_valid", {31'b0, a_valid}, 32'h0);
    chk("rst_epc", a_epc, 32'h0);
    chk("rst_wrap_curr", c_curr, 32'hFFFF_FFF8);
    RST = 1'b0;
    step();
    chk("run0_curr", a_curr, 32'h0);
    chk("run0_valid", {31'b0, a_valid}, 32'h1);
    chk("wrap0", c_curr, 32'hFFFF_FFF8);
    step();
    chk("run1_curr", a_curr, 32'h4);
    chk("wrap1", c_curr, 32'hFFFF_FFFC);
    chk("wrap1_next", c_next, 32'h0);
    step();
    chk("run2_curr", a_curr, 32'h8);
    chk("wrap2", c_curr, 32'h0);

    // Stall three cycles at 8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_curr", a_curr, 32'h8);
      chk("stall_next", a_next, 32'hC);
      chk("stall_valid", {31'b0, a_valid}, 32'h1);
    end
    stall = 1'b0;
    step();
    chk("unstall_curr", a_curr, 32'hC);

    // Branch with bubble (a: 1 cycle, b: 3 cycles)
    write = 1'b1; addr = 32'h0000_0AB4;
    step();
    write = 1'b0;
    chk("br_curr", a_curr, 32'h0AB4);
    chk("br_valid", {31'b0, a_valid}, 32'h0);
    chk("br3_valid0", {31'b0, b_valid}, 32'h0);
    stall = 1'b1;  // ignored in bubble
    step();
    stall = 1'b0;
    chk("br_bub_curr", a_curr, 32'h0AB4);
    chk("br_bub_valid", {31'b0, a_valid}, 32'h1);
    chk("br3_valid1", {31'b0, b_valid}, 32'h0);
    step();
    chk("br_inc", a_curr, 32'h0AB8);
    chk("br3_valid2", {31'b0, b_valid}, 32'h0);
    step();
    chk("br3_valid3", {31'b0, b_valid}, 32'h1);
    chk("br3_curr", b_curr, 32'h0AB4);
    step();
    chk("br3_inc", b_curr, 32'h0AB8);

    // Move a to 0x20 for the trap test
    write = 1'b1; addr = 32'h0000_001C;
    step();
    write = 1'b0;
    step(); step();
    chk("pre_trap_curr", a_curr, 32'h20);

    // Trap + write together: trap wins
    trap = 1'b1; write = 1'b1; addr = 32'h0000_0500;
    step();
    trap = 1'b0; write = 1'b0;
    chk("trap_curr", a_curr, 32'h100);
    chk("trap_epc", a_epc, 32'h20);
    chk("trap_valid", {31'b0, a_valid}, 32'h0);
    step();
    chk("trap_bub_curr", a_curr, 32'h100);
    step(); step();
    chk("trap_inc2", a_curr, 32'h108);

    // mret + write: mret wins
    mret = 1'b1; write = 1'b1; addr = 32'h0000_0700;
    step();
    mret = 1'b0; write = 1'b0;
    chk("mret_curr", a_curr, 32'h20);
    chk("mret_epc", a_epc, 32'h20);
    step();
    chk("mret_valid", {31'b0, a_valid}, 32'h1);

    // Misaligned write target
    write = 1'b1; addr = 32'h0000_0AB6;
    step();
    write = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
    chk("mis_curr", a_curr, 32'h100);
    chk("mis_epc", a_epc, 32'h20);
    chk("mis_pulse", {31'b0, a_mis}, 32'h1);
`else
    chk("mis_curr", a_curr, 32'h0AB4);
    chk("mis_pulse", {31'b0, a_mis}, 32'h0);
`endif
    step();
    chk("mis_clear", {31'b0, a_mis}, 32'h0);

    // Reset mid-bubble discards pending state
    write = 1'b1; addr = 32'h0000_0F00;
    step();
    write = 1'b0;
    chk("pre_rst_bub_valid", {31'b0, b_valid}, 32'h0);
    RST = 1'b1;
    step();
    chk("rst_bub_curr", b_curr, 32'h0);
    chk("rst_bub_valid", {31'b0, b_valid}, 32'h0);
    chk("rst_bub_epc", a_epc, 32'h0);
    RST = 1'b0;
    step();
    chk("rst_bub_rel_valid", {31'b0, b_valid}, 32'h1);
    chk("rst_bub_rel_curr", b_curr, 32'h0);
    step();
    chk("rst_bub_inc", b_curr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
